phy_read_mode: RTL and testbench



---
 rtl/phy_read_mode_if.sv | 24 ++
 rtl/phy_read_mode.sv | 157 +++++++++++++++
 tb/tb_phy_read_mode.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/phy_read_mode_if.sv
// Drain-side bus from the PHY read path to the channel Read Buffer.
// The master modport is the PHY producer, and the slave modport is the Read Buffer.
interface phy_read_mode_if #(
  parameter int MEM_DATAWIDTH = 64
);
  logic [MEM_DATAWIDTH-1:0] outdata;
  logic                     outvalid;
  logic                     outlast;
  logic                     outready;

  modport master (
    output outdata,
    output outvalid,
    output outlast,
    input  outready
  );

  modport slave (
    input  outdata,
    input  outvalid,
    input  outlast,
    output outready
  );
endinterface

// File: rtl/phy_read_mode.sv
// PHY read capture: buffers whole DQ bursts, checks the DQS strobe, and drains committed beats first-word-fall-through.
// Capture never stalls; outready back-pressure only affects drain and, through free space, burst overflow.
module phy_read_mode #(
  parameter int PHY_CHANNEL   = 0,
  parameter int MEM_DATAWIDTH = 64,
  parameter int PHYFIFODEPTH  = 32,
  parameter int BURST_LENGTH  = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     dqs_t,
  input  logic                     dqs_c,
  input  logic [MEM_DATAWIDTH-1:0] indata,
  input  logic                     inflag,
  phy_read_mode_if.master          rb,
  output logic                     outACK,
  output logic                     dqsErr,
  output logic                     abortErr,
  output logic                     overflow
);

  localparam int PTR_W  = $clog2(PHYFIFODEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int BEAT_W = $clog2(BURST_LENGTH);

  if (PHY_CHANNEL < 0 || BURST_LENGTH < 2 || (BURST_LENGTH & (BURST_LENGTH - 1)) != 0 ||
      (PHYFIFODEPTH % BURST_LENGTH) != 0) begin : g_cfg_err
    $error("phy_read_mode: illegal parameter set");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_CAP,
    S_DROP
  } state_t;

  state_t state, state_nxt;

  logic [MEM_DATAWIDTH-1:0] fifo [PHYFIFODEPTH];

  logic [PTR_W-1:0]  wr_ptr, commit_ptr, rd_ptr;
  logic [BEAT_W-1:0] beat_cnt, rd_beat;
  logic [CNT_W-1:0]  committed_cnt;
  logic              prev_dqs, dqs_acc;

  logic cap_en, drop_start, abort, last_beat, pop, space_ok, dqs_viol;

  // Depth need not be a power of two, so wrap explicitly.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    ptr_inc = (p == PTR_W'(PHYFIFODEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign space_ok  = (CNT_W'(PHYFIFODEPTH) - committed_cnt) >= CNT_W'(BURST_LENGTH);
  assign last_beat = cap_en && (beat_cnt == BEAT_W'(BURST_LENGTH - 1));
  assign dqs_viol  = (dqs_c == dqs_t) ||
                     ((state == S_IDLE) ? !dqs_t : (dqs_t == prev_dqs));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (inflag) state_nxt = space_ok ? S_CAP : S_DROP;
      S_CAP:  if (!inflag || last_beat) state_nxt = S_IDLE;
      S_DROP: if (!inflag) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    cap_en     = 1'b0;
    drop_start = 1'b0;
    abort      = 1'b0;
    case (state)
      S_IDLE: begin
        if (inflag) begin
          cap_en     = space_ok;
          drop_start = !space_ok;
        end
      end
      S_CAP: begin
        cap_en = inflag;
        abort  = !inflag;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (cap_en) fifo[wr_ptr] <= indata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr        <= '0;
      commit_ptr    <= '0;
      rd_ptr        <= '0;
      beat_cnt      <= '0;
      rd_beat       <= '0;
      committed_cnt <= '0;
      prev_dqs      <= 1'b0;
      dqs_acc       <= 1'b0;
      outACK        <= 1'b0;
      dqsErr        <= 1'b0;
      abortErr      <= 1'b0;
      overflow      <= 1'b0;
    end else begin
      outACK   <= 1'b0;
      dqsErr   <= 1'b0;
      abortErr <= abort;
      overflow <= drop_start;

      if (cap_en) begin
        wr_ptr   <= ptr_inc(wr_ptr);
        prev_dqs <= dqs_t;
        if (last_beat) begin
          beat_cnt   <= '0;
          dqs_acc    <= 1'b0;
          commit_ptr <= ptr_inc(wr_ptr);
          outACK     <= 1'b1;
          dqsErr     <= dqs_acc | dqs_viol;
        end else begin
          beat_cnt <= beat_cnt + 1'b1;
          dqs_acc  <= dqs_acc | dqs_viol;
        end
      end

      // Roll back a partial burst so none of it ever reaches the drain side.
      if (abort) begin
        wr_ptr   <= commit_ptr;
        beat_cnt <= '0;
        dqs_acc  <= 1'b0;
      end

      if (pop) begin
        rd_ptr  <= ptr_inc(rd_ptr);
        rd_beat <= rd_beat + 1'b1;
      end

      case ({last_beat, pop})
        2'b10:   committed_cnt <= committed_cnt + CNT_W'(BURST_LENGTH);
        2'b01:   committed_cnt <= committed_cnt - 1'b1;
        2'b11:   committed_cnt <= committed_cnt + CNT_W'(BURST_LENGTH - 1);
        default: ;
      endcase
    end
  end

  assign rb.outvalid = (committed_cnt != '0);
  assign rb.outdata  = rb.outvalid ? fifo[rd_ptr] : '0;
  assign rb.outlast  = rb.outvalid && (rd_beat == BEAT_W'(BURST_LENGTH - 1));
  assign pop         = rb.outvalid && rb.outready;

endmodule

// File: tb/tb_phy_read_mode.sv
// Scoreboard bench for phy_read_mode: expected beats are queued as bursts are driven and checked on drain.
module tb_phy_read_mode;

  localparam int W     = 64;
  localparam int DEPTH = 32;
  localparam int BL    = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         dqs_t, dqs_c, inflag;
  logic [W-1:0] indata;
  logic         outACK, dqsErr, abortErr, overflow;

  phy_read_mode_if #(.MEM_DATAWIDTH(W)) rb ();

  phy_read_mode #(
    .PHY_CHANNEL  (0),
    .MEM_DATAWIDTH(W),
    .PHYFIFODEPTH (DEPTH),
    .BURST_LENGTH (BL)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .dqs_t   (dqs_t),
    .dqs_c   (dqs_c),
    .indata  (indata),
    .inflag  (inflag),
    .rb      (rb),
    .outACK  (outACK),
    .dqsErr  (dqsErr),
    .abortErr(abortErr),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int n_ack, n_dqs, n_abort, n_ov, n_pop;
  logic [W:0] sb[$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Beats accepted at the next rising edge are checked against the queue head.
  always @(negedge clk) begin
    if (!rst) begin
      if (outACK)   n_ack++;
      if (dqsErr)   n_dqs++;
      if (abortErr) n_abort++;
      if (overflow) n_ov++;
      if (rb.outvalid && rb.outready) begin
        logic [W:0] e;
        chk("sb_empty", 64'(sb.size() == 0), 64'd0);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          chk("beat_data", rb.outdata, e[W-1:0]);
          chk("beat_last", 64'(rb.outlast), 64'(e[W]));
        end
        n_pop++;
      end
    end
  end

  task automatic clr_counts();
    n_ack = 0; n_dqs = 0; n_abort = 0; n_ov = 0; n_pop = 0;
  endtask

  // Drives nb beats starting one cycle later; returns #1 after the edge that samples the last beat.
  task automatic send(input logic [W-1:0] base, input int nb, input int bad, input bit push,
                      input int rdy_at);
    for (int k = 0; k < nb; k++) begin
      logic d;
      @(posedge clk); #1;
      d = ((k % 2) == 0);
      if ((k % BL) == bad) d = ~d;
      inflag = 1'b1;
      indata = base + W'(k);
      dqs_t  = d;
      dqs_c  = ~d;
      if (k == rdy_at) rb.outready = 1'b1;
      if (push) sb.push_back({((k % BL) == BL - 1), base + W'(k)});
    end
    @(posedge clk); #1;
    inflag = 1'b0;
    dqs_t  = 1'b0;
    dqs_c  = 1'b1;
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 300 && (sb.size() != 0 || rb.outvalid); i++) begin
      @(posedge clk); #2;
    end
    chk({tag, "_sb_left"}, 64'(sb.size()), 64'd0);
    chk({tag, "_valid_idle"}, 64'(rb.outvalid), 64'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; inflag = 1'b0; indata = '0; dqs_t = 1'b0; dqs_c = 1'b1;
    rb.outready = 1'b0;
    clr_counts();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", 64'(rb.outvalid), 64'd0);
    chk("rst_last", 64'(rb.outlast), 64'd0);
    chk("rst_data", rb.outdata, 64'd0);
    chk("rst_ack", 64'(outACK), 64'd0);
    chk("rst_dqserr", 64'(dqsErr), 64'd0);
    chk("rst_abort", 64'(abortErr), 64'd0);
    chk("rst_ovf", 64'(overflow), 64'd0);
    @(negedge clk); rst = 1'b0;

    // Single clean burst
    rb.outready = 1'b1;
    send(64'h1000, BL, -1, 1, -1);
    chk("t1_ack", 64'(outACK), 64'd1);
    chk("t1_dqserr", 64'(dqsErr), 64'd0);
    chk("t1_first", rb.outdata, 64'h1000);
    drain("t1");
    chk("t1_ack_cnt", 64'(n_ack), 64'd1);
    chk("t1_pop_cnt", 64'(n_pop), 64'd8);

    // Strobe not toggled on beat 3
    clr_counts();
    send(64'h1800, BL, 3, 1, -1);
    chk("t2_ack", 64'(outACK), 64'd1);
    chk("t2_dqserr", 64'(dqsErr), 64'd1);
    drain("t2");
    chk("t2_dqs_cnt", 64'(n_dqs), 64'd1);
    chk("t2_pop_cnt", 64'(n_pop), 64'd8);

    // Window closes after 5 beats, then a full burst
    clr_counts();
    send(64'h1500, 5, -1, 0, -1);
    @(posedge clk); #1;
    chk("t3_abort", 64'(abortErr), 64'd1);
    chk("t3_no_ack", 64'(outACK), 64'd0);
    send(64'h2000, BL, -1, 1, -1);
    chk("t3_ack", 64'(outACK), 64'd1);
    drain("t3");
    chk("t3_abort_cnt", 64'(n_abort), 64'd1);
    chk("t3_pop_cnt", 64'(n_pop), 64'd8);

    // Fill the FIFO with outready low; the fifth burst must overflow
    clr_counts();
    rb.outready = 1'b0;
    for (int b = 0; b < 4; b++) begin
      send(64'h3000 + 64'(b * 16), BL, -1, 1, -1);
      chk("t4_ack", 64'(outACK), 64'd1);
    end
    send(64'h3100, BL, -1, 0, -1);
    chk("t4_no_ack", 64'(outACK), 64'd0);
    chk("t4_ack_cnt", 64'(n_ack), 64'd4);
    chk("t4_ovf_cnt", 64'(n_ov), 64'd1);
    chk("t4_head", rb.outdata, 64'h3000);
    rb.outready = 1'b1;
    drain("t4");
    chk("t4_pop_cnt", 64'(n_pop), 64'd32);

    // Commit coincident with the first pop; the write side wraps 31 -> 0
    clr_counts();
    rb.outready = 1'b0;
    send(64'h4000, BL, -1, 1, -1);
    send(64'h4100, BL, -1, 1, BL - 1);
    chk("t5_ack", 64'(outACK), 64'd1);
    chk("t5_head", rb.outdata, 64'h4001);
    drain("t5");
    chk("t5_pop_cnt", 64'(n_pop), 64'd16);

    // Reset at beat 4 with one burst pending
    clr_counts();
    rb.outready = 1'b0;
    send(64'h5000, BL, -1, 0, -1);
    chk("t6_pending", 64'(rb.outvalid), 64'd1);
    send(64'h5100, 4, -1, 0, -1);
    rst = 1'b1;
    #1;
    chk("t6_rst_valid", 64'(rb.outvalid), 64'd0);
    chk("t6_rst_last", 64'(rb.outlast), 64'd0);
    chk("t6_rst_data", rb.outdata, 64'd0);
    chk("t6_rst_ack", 64'(outACK), 64'd0);
    chk("t6_rst_abort", 64'(abortErr), 64'd0);
    @(negedge clk);
    @(negedge clk); rst = 1'b0;
    rb.outready = 1'b1;
    send(64'h6000, BL, -1, 1, -1);
    chk("t6_ack", 64'(outACK), 64'd1);
    chk("t6_head", rb.outdata, 64'h6000);
    drain("t6");
    chk("t6_pop_cnt", 64'(n_pop), 64'd8);
    chk("t6_abort_cnt", 64'(n_abort), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
